// File: rtl/bit_usage_pkg.sv
// Shared types for the bit usage monitor: scan FSM state encoding.
package bit_usage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bit_usage_chan.sv
// One monitored channel: sticky driven/used masks plus the shadow copy taken at report start.
module bit_usage_chan #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_hit,
    input  logic             rd_hit,
    input  logic [WIDTH-1:0] wr_mask,
    input  logic [WIDTH-1:0] rd_mask,
    input  logic             clear,
    input  logic             snap,
    output logic [WIDTH-1:0] shadow_drv,
    output logic [WIDTH-1:0] shadow_used
);

    logic [WIDTH-1:0] drv;
    logic [WIDTH-1:0] used;
    logic [WIDTH-1:0] drv_next;
    logic [WIDTH-1:0] used_next;

    // clear overrides any same-cycle observation
    always_comb begin
        drv_next  = drv;
        used_next = used;
        if (clear) begin
            drv_next  = '0;
            used_next = '0;
        end else begin
            if (wr_hit) drv_next  = drv | wr_mask;
            if (rd_hit) used_next = used | rd_mask;
        end
    end

    // The snapshot captures next-state masks so the request cycle's own traffic is included
    always_ff @(posedge clk) begin
        if (rst) begin
            drv         <= '0;
            used        <= '0;
            shadow_drv  <= '0;
            shadow_used <= '0;
        end else begin
            drv  <= drv_next;
            used <= used_next;
            if (snap) begin
                shadow_drv  <= drv_next;
                shadow_used <= used_next;
            end
        end
    end

endmodule

// File: rtl/bit_usage_mon.sv
// Multi-channel bus bit usage monitor: sticky driven/used masks with a serial
// per-channel report of undriven and driven-but-unused bits.
module bit_usage_mon
    import bit_usage_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter int               NCHAN       = 4,
    parameter logic [WIDTH-1:0] IGNORE_MASK = '0,
    localparam int              CW          = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    input  logic [CW-1:0]    wr_chan,
    input  logic [WIDTH-1:0] wr_mask,
    input  logic             rd_valid,
    input  logic [CW-1:0]    rd_chan,
    input  logic [WIDTH-1:0] rd_mask,
    input  logic             clear,
    input  logic             rpt_req,
    output logic             busy,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CW-1:0]    rpt_chan,
    output logic [WIDTH-1:0] rpt_undrv,
    output logic [WIDTH-1:0] rpt_unused,
    output logic             rpt_clean,
    output logic             rpt_done
);

    state_t           state;
    state_t           state_next;
    logic             snap;
    logic             accept;
    logic             last_chan;
    logic [WIDTH-1:0] sh_drv  [NCHAN];
    logic [WIDTH-1:0] sh_used [NCHAN];

    assign snap      = (state == IDLE) && rpt_req;
    assign accept    = (state == SCAN) && rpt_ready;
    assign last_chan = (rpt_chan == CW'(NCHAN - 1));

    for (genvar i = 0; i < NCHAN; i++) begin : g_chan
        bit_usage_chan #(.WIDTH(WIDTH)) u_chan (
            .clk         (clk),
            .rst         (rst),
            .wr_hit      (wr_valid && (int'(wr_chan) == i)),
            .rd_hit      (rd_valid && (int'(rd_chan) == i)),
            .wr_mask     (wr_mask),
            .rd_mask     (rd_mask),
            .clear       (clear),
            .snap        (snap),
            .shadow_drv  (sh_drv[i]),
            .shadow_used (sh_used[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Report handshake: a beat transfers on any cycle with rpt_valid & rpt_ready;
    // while rpt_ready is low the beat and rpt_chan are held unchanged indefinitely.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (rpt_req) state_next = SCAN;
            SCAN:    if (accept && last_chan) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_chan <= '0;
        end else if (snap) begin
            rpt_chan <= '0;
        end else if (accept && !last_chan) begin
            rpt_chan <= rpt_chan + 1'b1;
        end
    end

    always_comb begin
        busy       = (state != IDLE);
        rpt_valid  = (state == SCAN);
        rpt_done   = (state == DONE);
        rpt_undrv  = '0;
        rpt_unused = '0;
        if (state == SCAN) begin
            rpt_undrv  = ~sh_drv[rpt_chan] & ~IGNORE_MASK;
            rpt_unused = sh_drv[rpt_chan] & ~sh_used[rpt_chan] & ~IGNORE_MASK;
        end
        rpt_clean = (state == SCAN) && (rpt_undrv == '0) && (rpt_unused == '0);
    end

endmodule

// File: tb/tb_bit_usage_mon.sv
// Randomized self-checking bench for bit_usage_mon against a mask-level reference model.
module tb_bit_usage_mon;

    localparam int               W     = 16;
    localparam int               NCH   = 4;
    localparam int               CW    = 2;
    localparam logic [W-1:0]     IGN   = 16'h0001;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic [CW-1:0] wr_chan;
    logic [W-1:0]  wr_mask;
    logic          rd_valid;
    logic [CW-1:0] rd_chan;
    logic [W-1:0]  rd_mask;
    logic          clear;
    logic          rpt_req;
    logic          busy;
    logic          rpt_valid;
    logic          rpt_ready;
    logic [CW-1:0] rpt_chan;
    logic [W-1:0]  rpt_undrv;
    logic [W-1:0]  rpt_unused;
    logic          rpt_clean;
    logic          rpt_done;

    // reference model: live masks per channel and expected report beats {undrv, unused}
    logic [W-1:0]   drv_m  [NCH];
    logic [W-1:0]   used_m [NCH];
    logic [2*W-1:0] exp_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    bit_usage_mon #(.WIDTH(W), .NCHAN(NCH), .IGNORE_MASK(IGN)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_chan    (wr_chan),
        .wr_mask    (wr_mask),
        .rd_valid   (rd_valid),
        .rd_chan    (rd_chan),
        .rd_mask    (rd_mask),
        .clear      (clear),
        .rpt_req    (rpt_req),
        .busy       (busy),
        .rpt_valid  (rpt_valid),
        .rpt_ready  (rpt_ready),
        .rpt_chan   (rpt_chan),
        .rpt_undrv  (rpt_undrv),
        .rpt_unused (rpt_unused),
        .rpt_clean  (rpt_clean),
        .rpt_done   (rpt_done)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        wr_valid = 1'b0; wr_chan = '0; wr_mask = '0;
        rd_valid = 1'b0; rd_chan = '0; rd_mask = '0;
        clear = 1'b0; rpt_req = 1'b0;
    endtask

    task automatic random_traffic();
        wr_valid = 1'($urandom_range(1));
        wr_chan  = CW'($urandom_range(NCH - 1));
        wr_mask  = W'($urandom) & W'($urandom);
        rd_valid = 1'($urandom_range(1));
        rd_chan  = CW'($urandom_range(NCH - 1));
        rd_mask  = W'($urandom);
        clear    = ($urandom_range(15) == 0);
    endtask

    // one clock: model applies the same inputs the DUT samples, outputs observed 1ns later
    task automatic cycle();
        @(posedge clk);
        if (rst || clear) begin
            for (int c = 0; c < NCH; c++) begin
                drv_m[c]  = '0;
                used_m[c] = '0;
            end
        end else begin
            if (wr_valid) drv_m[wr_chan] = drv_m[wr_chan] | wr_mask;
            if (rd_valid) used_m[rd_chan] = used_m[rd_chan] | rd_mask;
        end
        #1;
    endtask

    task automatic check_quiet(input string name);
        n_chk++;
        if (busy !== 1'b0 || rpt_valid !== 1'b0 || rpt_done !== 1'b0 || rpt_undrv !== '0 ||
            rpt_unused !== '0 || rpt_clean !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: busy=%b valid=%b done=%b undrv=%h unused=%h clean=%b, want all 0",
                     name, busy, rpt_valid, rpt_done, rpt_undrv, rpt_unused, rpt_clean);
        end
    endtask

    // Request a report, then follow every beat against the snapshot taken from the model.
    // stall_chan >= 0 holds rpt_ready low 3 cycles on that channel while writing ch1 and re-requesting.
    task automatic run_report(input int ready_pct, input bit traffic, input int stall_chan);
        int beat = 0;
        int cyc = 0;
        int stall = 3;
        logic [W-1:0] e_undrv, e_unused;
        rpt_req = 1'b1;
        cycle();
        idle_inputs();
        exp_q.delete();
        for (int c = 0; c < NCH; c++)
            exp_q.push_back({~drv_m[c] & ~IGN, drv_m[c] & ~used_m[c] & ~IGN});
        while (beat < NCH && cyc < 200) begin
            cyc++;
            {e_undrv, e_unused} = exp_q[0];
            n_chk++;
            if (rpt_valid !== 1'b1 || busy !== 1'b1 || rpt_done !== 1'b0) begin
                n_fail++;
                $display("FAIL scan_flags beat %0d: valid=%b busy=%b done=%b, want 1 1 0",
                         beat, rpt_valid, busy, rpt_done);
            end
            n_chk++;
            if (rpt_chan !== CW'(beat)) begin
                n_fail++;
                $display("FAIL rpt_chan: got %0d want %0d", rpt_chan, beat);
            end
            n_chk++;
            if (rpt_undrv !== e_undrv || rpt_unused !== e_unused) begin
                n_fail++;
                $display("FAIL beat_data ch%0d: undrv=%h unused=%h want %h %h",
                         beat, rpt_undrv, rpt_unused, e_undrv, e_unused);
            end
            n_chk++;
            if (rpt_clean !== (e_undrv == '0 && e_unused == '0)) begin
                n_fail++;
                $display("FAIL rpt_clean ch%0d: got %b want %b",
                         beat, rpt_clean, (e_undrv == '0 && e_unused == '0));
            end
            idle_inputs();
            if (beat == stall_chan && stall > 0) begin
                stall--;
                rpt_ready = 1'b0;
                wr_valid  = 1'b1;
                wr_chan   = 2'd1;
                wr_mask   = 16'hFFFF;
                rpt_req   = 1'b1;
            end else begin
                rpt_ready = ($urandom_range(99) < ready_pct);
                if (traffic) begin
                    random_traffic();
                    rpt_req = ($urandom_range(3) == 0);
                end
            end
            if (rpt_ready) begin
                void'(exp_q.pop_front());
                beat++;
            end
            cycle();
        end
        idle_inputs();
        rpt_ready = 1'b0;
        n_chk++;
        if (beat != NCH) begin
            n_fail++;
            $display("FAIL scan_timeout: %0d beats accepted, want %0d", beat, NCH);
        end
        n_chk++;
        if (rpt_done !== 1'b1 || busy !== 1'b1 || rpt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: done=%b busy=%b valid=%b, want 1 1 0", rpt_done, busy, rpt_valid);
        end
        if (ready_pct == 100 && stall_chan < 0) begin
            n_chk++;
            if (cyc + 1 != NCH + 1) begin
                n_fail++;
                $display("FAIL scan_length: done on cycle %0d want %0d", cyc + 1, NCH + 1);
            end
        end
        cycle();
        check_quiet("after_done");
        cycle();
        check_quiet("no_second_done");
    endtask

    task automatic test_reset();
        idle_inputs();
        rpt_ready = 1'b0;
        rst = 1'b1;
        repeat (3) cycle();
        check_quiet("reset_outputs");
        n_chk++;
        if (rpt_chan !== '0) begin
            n_fail++;
            $display("FAIL reset_chan: got %0d want 0", rpt_chan);
        end
        rst = 1'b0;
        cycle();
        check_quiet("post_reset");
    endtask

    task automatic test_empty_report();
        run_report(100, 1'b0, -1);
    endtask

    task automatic test_wr_rd();
        wr_valid = 1'b1; wr_chan = 2'd2; wr_mask = 16'hFC00;
        cycle();
        idle_inputs();
        rd_valid = 1'b1; rd_chan = 2'd2; rd_mask = 16'h8400;
        cycle();
        idle_inputs();
        run_report(100, 1'b0, -1);
    endtask

    task automatic test_same_cycle();
        wr_valid = 1'b1; wr_chan = 2'd1; wr_mask = 16'hFFFF;
        rd_valid = 1'b1; rd_chan = 2'd1; rd_mask = 16'hFFFF;
        cycle();
        idle_inputs();
        run_report(100, 1'b0, -1);
    endtask

    task automatic test_clear_wins();
        wr_valid = 1'b1; wr_chan = 2'd0; wr_mask = 16'h00F0;
        cycle();
        clear = 1'b1; wr_mask = 16'hFFFF;
        cycle();
        idle_inputs();
        run_report(100, 1'b0, -1);
    endtask

    task automatic test_stall();
        run_report(100, 1'b0, 1);
        run_report(100, 1'b0, -1);
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        rpt_req = 1'b1;
        cycle();
        idle_inputs();
        rpt_ready = 1'b1;
        while (rpt_chan !== 2'd2 && cyc < 20) begin
            cycle();
            cyc++;
        end
        n_chk++;
        if (rpt_chan !== 2'd2 || rpt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reach_chan2: chan=%0d valid=%b want 2 1", rpt_chan, rpt_valid);
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        rpt_ready = 1'b0;
        check_quiet("mid_scan_reset");
        cycle();
        check_quiet("no_done_after_reset");
        run_report(100, 1'b0, -1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            repeat (12) begin
                random_traffic();
                cycle();
            end
            idle_inputs();
            run_report(60, 1'b1, -1);
        end
    endtask

    initial begin
        for (int c = 0; c < NCH; c++) begin
            drv_m[c]  = '0;
            used_m[c] = '0;
        end
        test_reset();
        test_empty_report();
        test_wr_rd();
        test_same_cycle();
        test_clear_wins();
        test_stall();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
